// File: rtl/homo_pkg.sv
// Shared defaults and SAD width helper for homo_window_detector.
package homo_pkg;

    localparam int DEFAULT_N     = 5;
    localparam int DEFAULT_PIX_W = 8;
    localparam int DEFAULT_DELAY = 32;

    // N*N*(2^pix_w-1) < 2^(pix_w + clog2(n*n)), so the SAD never wraps.
    function automatic int sad_width(input int n, input int pix_w);
        return pix_w + $clog2(n * n);
    endfunction

endpackage

// File: rtl/homo_delay_line.sv
// Fixed-depth shift register used to align detector results; DEPTH=0 is a wire.
module homo_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = i_clk ^ i_rst;
            assign o_data         = i_data;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            // NOTE: every stage is reset (not just the output) so windows in flight are discarded on reset.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= i_data;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign o_data = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/homo_window_detector.sv
// Stereo window homogeneity detector: 3-stage SAD pipeline plus DELAY-cycle alignment.
// Optional per-frame textured-window statistics are enabled with `define HOMO_STATS_EN.
module homo_window_detector
    import homo_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int PIX_W = DEFAULT_PIX_W,
    parameter int DELAY = DEFAULT_DELAY,
    parameter int SUM_W = sad_width(N, PIX_W)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic                 i_sof,
    input  logic [SUM_W-1:0]     i_thresh,
    input  logic [N*N*PIX_W-1:0] i_win_l,
    input  logic [N*N*PIX_W-1:0] i_win_r,
    output logic                 o_valid,
    output logic                 o_sof,
    output logic                 o_homo,
    output logic [SUM_W-1:0]     o_sad,
    output logic [31:0]          o_hcnt,
    output logic                 o_hcnt_valid
);

    localparam int NN   = N * N;
    localparam int DL_W = SUM_W + 3;

    // Threshold latch; the sof window itself sees the incoming value.
    logic [SUM_W-1:0] thresh_reg;
    logic [SUM_W-1:0] thresh_eff;
    logic             sof_in;

    assign sof_in     = i_valid && i_sof;
    assign thresh_eff = sof_in ? i_thresh : thresh_reg;

    // S1: per-pixel absolute differences
    logic [PIX_W-1:0] diff_c [NN];
    logic [PIX_W-1:0] s1_diff [NN];
    logic [SUM_W-1:0] s1_thresh;
    logic             s1_valid, s1_sof;

    // NOTE: locals in always_comb use blocking '='; all clocked state below uses non-blocking '<='.
    always_comb begin : abs_diff
        logic [PIX_W-1:0] pl, pr;
        pl = '0;
        pr = '0;
        for (int k = 0; k < NN; k++) begin
            pl        = i_win_l[k*PIX_W +: PIX_W];
            pr        = i_win_r[k*PIX_W +: PIX_W];
            diff_c[k] = (pl >= pr) ? pl - pr : pr - pl;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            thresh_reg <= '1;
            s1_valid   <= 1'b0;
            s1_sof     <= 1'b0;
        end else begin
            s1_valid <= i_valid;
            s1_sof   <= sof_in;
            if (sof_in) thresh_reg <= i_thresh;
        end
    end

    // NOTE: payload registers carry no reset; the valid tags alone decide whether they mean anything.
    always_ff @(posedge i_clk) begin
        if (i_valid) begin
            for (int k = 0; k < NN; k++) s1_diff[k] <= diff_c[k];
            s1_thresh <= thresh_eff;
        end
    end

    // S2: row sums
    logic [SUM_W-1:0] row_c [N];
    logic [SUM_W-1:0] s2_row [N];
    logic [SUM_W-1:0] s2_thresh;
    logic             s2_valid, s2_sof;

    always_comb begin : row_sum
        logic [SUM_W-1:0] acc;
        acc = '0;
        for (int r = 0; r < N; r++) begin
            acc = '0;
            for (int c = 0; c < N; c++) acc = acc + SUM_W'(s1_diff[r*N + c]);
            row_c[r] = acc;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s2_valid <= 1'b0;
            s2_sof   <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_sof   <= s1_valid && s1_sof;
        end
    end

    always_ff @(posedge i_clk) begin
        if (s1_valid) begin
            for (int r = 0; r < N; r++) s2_row[r] <= row_c[r];
            s2_thresh <= s1_thresh;
        end
    end

    // S3: total SAD and strict compare; payload holds through bubbles
    logic [SUM_W-1:0] total_c;
    logic [SUM_W-1:0] s3_sad;
    logic             s3_homo, s3_valid, s3_sof;

    always_comb begin : total_sum
        logic [SUM_W-1:0] acc;
        acc = '0;
        for (int r = 0; r < N; r++) acc = acc + s2_row[r];
        total_c = acc;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s3_valid <= 1'b0;
            s3_sof   <= 1'b0;
            s3_homo  <= 1'b0;
            s3_sad   <= '0;
        end else begin
            s3_valid <= s2_valid;
            s3_sof   <= s2_valid && s2_sof;
            if (s2_valid) begin
                s3_sad  <= total_c;
                s3_homo <= total_c > s2_thresh;
            end
        end
    end

    // Bubbles shift S3's held payload along, so the ports keep the last valid result.
    logic [DL_W-1:0] dl_in, dl_out;
    assign dl_in = {s3_valid, s3_sof, s3_homo, s3_sad};

    homo_delay_line #(
        .WIDTH (DL_W),
        .DEPTH (DELAY)
    ) u_delay (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_data (dl_in),
        .o_data (dl_out)
    );

    assign {o_valid, o_sof, o_homo, o_sad} = dl_out;

`ifdef HOMO_STATS_EN
    logic [31:0] hcnt_acc;
    logic        sof_seen;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hcnt_acc     <= '0;
            sof_seen     <= 1'b0;
            o_hcnt       <= '0;
            o_hcnt_valid <= 1'b0;
        end else begin
            o_hcnt_valid <= 1'b0;
            if (o_valid && o_sof) begin
                o_hcnt       <= hcnt_acc;
                o_hcnt_valid <= sof_seen;
                sof_seen     <= 1'b1;
                hcnt_acc     <= {31'd0, o_homo};
            end else if (o_valid && o_homo && (hcnt_acc != '1)) begin
                hcnt_acc <= hcnt_acc + 32'd1;
            end
        end
    end
`else
    assign o_hcnt       = '0;
    assign o_hcnt_valid = 1'b0;
`endif

endmodule

// File: tb/tb_homo_window_detector.sv
// Self-checking bench for homo_window_detector: directed cases plus random windows vs a SAD model.
module tb_homo_window_detector;

    localparam int N     = 5;
    localparam int PIX_W = 8;
    localparam int DELAY = 32;
    localparam int SUM_W = PIX_W + $clog2(N*N);
    localparam int WIN_W = N*N*PIX_W;
    localparam int LAT   = 3 + DELAY;

    typedef struct packed {
        logic             valid;
        logic             sof;
        logic             homo;
        logic [SUM_W-1:0] sad;
    } rec_t;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b0;
    logic             i_valid = 1'b0;
    logic             i_sof = 1'b0;
    logic [SUM_W-1:0] i_thresh = '0;
    logic [WIN_W-1:0] i_win_l = '0;
    logic [WIN_W-1:0] i_win_r = '0;
    logic             o_valid, o_sof, o_homo, o_hcnt_valid;
    logic [SUM_W-1:0] o_sad;
    logic [31:0]      o_hcnt;

    homo_window_detector #(
        .N     (N),
        .PIX_W (PIX_W),
        .DELAY (DELAY)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .i_sof        (i_sof),
        .i_thresh     (i_thresh),
        .i_win_l      (i_win_l),
        .i_win_r      (i_win_r),
        .o_valid      (o_valid),
        .o_sof        (o_sof),
        .o_homo       (o_homo),
        .o_sad        (o_sad),
        .o_hcnt       (o_hcnt),
        .o_hcnt_valid (o_hcnt_valid)
    );

    always #5 i_clk = ~i_clk;

    // Reference model state
    rec_t             pipe_q[$];
    int               thr_m;
    logic             last_homo;
    logic [SUM_W-1:0] last_sad;
    logic [31:0]      cnt_m, hcnt_exp;
    logic             seen_m, pend_hv;
    int               vectors = 0;
    int               miscompares = 0;

    function automatic int sad_model(input logic [WIN_W-1:0] l, input logic [WIN_W-1:0] r);
        int s = 0;
        for (int k = 0; k < N*N; k++) begin
            int a, b;
            a = int'(l[k*PIX_W +: PIX_W]);
            b = int'(r[k*PIX_W +: PIX_W]);
            s += (a > b) ? a - b : b - a;
        end
        return s;
    endfunction

    function automatic logic [WIN_W-1:0] flat(input int val);
        logic [WIN_W-1:0] w;
        for (int k = 0; k < N*N; k++) w[k*PIX_W +: PIX_W] = PIX_W'(val);
        return w;
    endfunction

    function automatic logic [WIN_W-1:0] rand_win();
        logic [WIN_W-1:0] w;
        for (int k = 0; k < N*N; k++) w[k*PIX_W +: PIX_W] = PIX_W'($urandom);
        return w;
    endfunction

    task automatic reset_model();
        pipe_q.delete();
        repeat (LAT - 1) pipe_q.push_back('0);
        thr_m     = (1 << SUM_W) - 1;
        last_homo = 1'b0;
        last_sad  = '0;
        cnt_m     = '0;
        hcnt_exp  = '0;
        seen_m    = 1'b0;
        pend_hv   = 1'b0;
    endtask

    task automatic compare_all(input rec_t e);
        if (e.valid) begin
            last_homo = e.homo;
            last_sad  = e.sad;
        end
        vectors++;
        assert (o_valid === e.valid) else begin
            miscompares++;
            $error("FAIL o_valid: observed %b expected %b at %0t", o_valid, e.valid, $time);
        end
        vectors++;
        assert (o_sof === (e.valid && e.sof)) else begin
            miscompares++;
            $error("FAIL o_sof: observed %b expected %b at %0t", o_sof, e.valid && e.sof, $time);
        end
        vectors++;
        assert (o_homo === last_homo) else begin
            miscompares++;
            $error("FAIL o_homo: observed %b expected %b at %0t", o_homo, last_homo, $time);
        end
        vectors++;
        assert (o_sad === last_sad) else begin
            miscompares++;
            $error("FAIL o_sad: observed %0d expected %0d at %0t", o_sad, last_sad, $time);
        end
        vectors++;
        assert (o_hcnt_valid === pend_hv) else begin
            miscompares++;
            $error("FAIL o_hcnt_valid: observed %b expected %b at %0t", o_hcnt_valid, pend_hv, $time);
        end
        vectors++;
        assert (o_hcnt === hcnt_exp) else begin
            miscompares++;
            $error("FAIL o_hcnt: observed %0d expected %0d at %0t", o_hcnt, hcnt_exp, $time);
        end
        pend_hv = 1'b0;
`ifdef HOMO_STATS_EN
        if (e.valid && e.sof) begin
            hcnt_exp = cnt_m;
            pend_hv  = seen_m;
            seen_m   = 1'b1;
            cnt_m    = {31'd0, e.homo};
        end else if (e.valid && e.homo && cnt_m != 32'hFFFF_FFFF) begin
            cnt_m = cnt_m + 32'd1;
        end
`endif
    endtask

    task automatic step(input logic v, input logic s, input int th,
                        input logic [WIN_W-1:0] l, input logic [WIN_W-1:0] r);
        rec_t e;
        int   sad;
        i_valid  = v;
        i_sof    = s;
        i_thresh = SUM_W'(th);
        i_win_l  = l;
        i_win_r  = r;
        sad      = sad_model(l, r);
        if (v && s) thr_m = th;
        e.valid = v;
        e.sof   = v && s;
        e.homo  = v && (sad > thr_m);
        e.sad   = SUM_W'(sad);
        pipe_q.push_back(e);
        @(posedge i_clk);
        #1;
        compare_all(pipe_q.pop_front());
    endtask

    // Bubbles with random payload, thresholds and unqualified sof.
    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'($urandom), int'($urandom_range(0, 8191)), rand_win(), rand_win());
    endtask

    task automatic apply_reset(input int cycles);
        i_rst   = 1'b1;
        i_valid = 1'b1;
        #2;
        reset_model();
        compare_all('0);
        repeat (cycles) begin
            @(posedge i_clk);
            #1;
            compare_all('0);
        end
        i_rst = 1'b0;
    endtask

    initial begin
        logic [WIN_W-1:0] tex_l, tex_r, flat_w, w30;
        tex_l  = flat(255);
        tex_r  = flat(0);
        flat_w = flat(100);
        w30    = flat(50);
        w30[0 +: PIX_W] = 8'd60;

        #1;
        apply_reset(2);

        // Identical windows: SAD 0, not textured even with threshold 0
        step(1'b1, 1'b1, 0, flat_w, flat_w);
        idle(LAT + 1);

        // Maximum SAD against thresholds just below and at it
        step(1'b1, 1'b1, 6374, tex_l, tex_r);
        step(1'b1, 1'b1, 6375, tex_l, tex_r);
        idle(LAT + 1);

        // Threshold latched on sof survives a non-sof threshold change
        step(1'b1, 1'b1, 20, w30, flat(50));
        step(1'b1, 1'b0, 0, w30, flat(50));
        idle(LAT + 1);

        // Valid pattern 1,0,0,1,1
        step(1'b1, 1'b0, 0, rand_win(), rand_win());
        idle(2);
        step(1'b1, 1'b0, 0, rand_win(), rand_win());
        step(1'b1, 1'b0, 0, rand_win(), rand_win());
        idle(LAT + 1);

        // Ten windows in flight, then reset: none of them may emerge
        repeat (10) step(1'b1, 1'($urandom_range(0, 1)), 100, tex_l, tex_r);
        apply_reset(3);

        // Frame of 7 windows, 4 textured, closed by the next sof
        step(1'b1, 1'b1, 100, tex_l, tex_r);
        step(1'b1, 1'b0, 5000, tex_l, tex_r);
        step(1'b1, 1'b0, 0, flat_w, flat_w);
        idle(1);
        step(1'b1, 1'b0, 0, tex_l, tex_r);
        step(1'b1, 1'b0, 0, flat_w, flat_w);
        step(1'b1, 1'b0, 0, flat_w, flat_w);
        step(1'b1, 1'b0, 0, tex_l, tex_r);
        step(1'b1, 1'b1, 100, flat_w, flat_w);
        idle(LAT + 2);
`ifdef HOMO_STATS_EN
        vectors++;
        assert (o_hcnt === 32'd4) else begin
            miscompares++;
            $error("FAIL frame_hcnt: observed %0d expected 4", o_hcnt);
        end
`endif

        // Random windows with thresholds around typical random SAD
        for (int i = 0; i < 300; i++) begin
            logic v, s;
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 15) == 0);
            step(v, s, int'($urandom_range(1500, 2800)), rand_win(), rand_win());
        end
        idle(LAT + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
